// File: rtl/sram_cache_req_adapter_if.sv
// Request, response and SRAM-side signal bundle for sram_cache_req_adapter.
// The adapter connects through the slave modport; the master modport is the surrounding logic.
interface sram_cache_req_adapter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024
);
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8;
  localparam int unsigned AW = $clog2(NUM_WORDS);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [AW-1:0]         req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [BW-1:0]         req_be_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;

  logic                  sram_req_o;
  logic                  sram_we_o;
  logic [AW-1:0]         sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic [BW-1:0]         sram_be_o;
  logic [DATA_WIDTH-1:0] sram_rdata_i;

  logic                  idle_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    input  rsp_ready_i,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
    input  sram_rdata_i,
    output idle_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    output rsp_ready_i,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
    output sram_rdata_i,
    input  idle_o
  );
endinterface

// File: rtl/sram_cache_req_adapter.sv
// Valid/ready front-end for the cache SRAM: strobes one access per accepted request and
// buffers read data in a credit-protected response FIFO so the SRAM output is never held.
module sram_cache_req_adapter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  sram_cache_req_adapter_if.slave bus
);
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8;
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                  rd_pend_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

  logic          acc;
  logic          push;
  logic          pop;
  logic          credit_ok;
  logic [CW:0]   inflight;

  // Credit counts the read already strobed but not yet captured, so a read is only issued
  // when its data is guaranteed a slot one cycle later regardless of rsp_ready_i.
  assign inflight  = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
  assign credit_ok = inflight < (CW + 1)'(RSP_DEPTH);

  assign bus.req_ready_o = bus.req_we_i | credit_ok;
  assign acc             = bus.req_valid_i & bus.req_ready_o;

  assign bus.sram_req_o   = acc;
  assign bus.sram_we_o    = bus.req_we_i;
  assign bus.sram_addr_o  = bus.req_addr_i;
  assign bus.sram_wdata_o = bus.req_wdata_i;
  assign bus.sram_be_o    = bus.req_we_i ? bus.req_be_i : {BW{1'b0}};

  assign push = rd_pend_q;
  assign pop  = bus.rsp_valid_o & bus.rsp_ready_i;

  assign bus.rsp_valid_o = (cnt_q != '0);
  assign bus.rsp_rdata_o = fifo_q[rd_ptr_q];
  assign bus.idle_o      = (cnt_q == '0) & ~rd_pend_q;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rd_pend_q <= acc & ~bus.req_we_i;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      // SRAM output this cycle belongs to last cycle's read, even if a new access strobes now.
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.sram_rdata_i;
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> (cnt_q < CW'(RSP_DEPTH)));

  a_rdata_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.rsp_valid_o && !bus.rsp_ready_i) |=> $stable(bus.rsp_rdata_o));

endmodule

// File: tb/tb_sram_cache_req_adapter.sv
// Directed bench for sram_cache_req_adapter: behavioural SRAM, expected-response queue filled
// at request time, and an independent monitor that checks every response handshake.
module tb_sram_cache_req_adapter;
  localparam int unsigned DW    = 64;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;

  sram_cache_req_adapter_if #(.DATA_WIDTH(DW), .NUM_WORDS(WORDS)) bus ();

  sram_cache_req_adapter #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (WORDS),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          pops        = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sram_mem [WORDS];
  logic [63:0] shadow   [WORDS];

  function automatic logic [63:0] init_word(input int unsigned i);
    return {32'hC0DE_0000 | i, ~i};
  endfunction

  // Behavioural SRAM: registered read data, byte-masked writes.
  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) begin
        for (int b = 0; b < 8; b++) begin
          if (bus.sram_be_o[b]) sram_mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
        end
      end else begin
        bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      pops++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got %h expected none", bus.rsp_rdata_o);
      end else begin
        logic [63:0] want;
        want = exp_q.pop_front();
        if (bus.rsp_rdata_o !== want) begin
          miscompares++;
          $display("FAIL rsp_data: got %h expected %h", bus.rsp_rdata_o, want);
        end
      end
    end
  end

  task automatic do_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.req_be_i    = be;
    @(negedge clk);
    check("wr_ready", 64'(bus.req_ready_o), 64'd1);
    check("wr_sram_be", 64'(bus.sram_be_o), 64'(be));
    for (int b = 0; b < 8; b++) begin
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = '0;
  endtask

  // Single read whose expected data is supplied by the caller.
  task automatic do_read(input logic [9:0] a, input logic [63:0] want);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = a;
    bus.req_be_i    = 8'hFF;
    @(negedge clk);
    check("rd_ready", 64'(bus.req_ready_o), 64'd1);
    check("rd_sram_be", 64'(bus.sram_be_o), 64'd0);
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_be_i    = '0;
  endtask

  // Hold a read stream for ncyc cycles; addresses advance only on acceptance.
  task automatic read_burst(input logic [9:0] start, input int ncyc, output int acc);
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = start + 10'(acc);
      bus.req_be_i    = 8'hFF;
      @(negedge clk);
      if (bus.req_ready_o) begin
        check("burst_sram_be", 64'(bus.sram_be_o), 64'd0);
        exp_q.push_back(shadow[bus.req_addr_i]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    bus.req_be_i    = '0;
  endtask

  initial begin
    int acc;
    int pops0;
    for (int i = 0; i < int'(WORDS); i++) begin
      sram_mem[i] = init_word(i);
      shadow[i]   = init_word(i);
    end
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 64'd0);
    check("rst_idle", 64'(bus.idle_o), 64'd1);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_sram_req", 64'(bus.sram_req_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read: response valid two cycles after accept.
    do_write(10'h010, 64'h1122_3344_5566_7788, 8'hFF);
    do_read(10'h010, 64'h1122_3344_5566_7788);
    @(negedge clk);
    check("lat_n1_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("lat_n1_idle", 64'(bus.idle_o), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(bus.rsp_valid_o), 64'd1);
    @(negedge clk);
    check("lat_n3_idle", 64'(bus.idle_o), 64'd1);
    @(posedge clk);
    #1;

    // Partial write merges into the low four bytes.
    do_write(10'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    do_read(10'h010, 64'h1122_3344_AAAA_AAAA);
    repeat (3) @(posedge clk);
    #1;

    // 16 back-to-back reads with a free consumer: one accept and one response per cycle.
    pops0 = pops;
    read_burst(10'h000, 16, acc);
    check("b2b_accepts", 64'(acc), 64'd16);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_responses", 64'(pops - pops0), 64'd16);

    // Stalled consumer: credit limits reads to DEPTH, writes still pass.
    bus.rsp_ready_i = 1'b0;
    read_burst(10'h020, 8, acc);
    check("stall_accepts", 64'(acc), 64'(DEPTH));
    @(negedge clk);
    check("stall_ready_rd", 64'(bus.req_ready_o), 64'd0);
    check("stall_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    @(posedge clk);
    #1;
    do_write(10'h300, 64'h0BAD_F00D_DEAD_BEEF, 8'h3C);
    pops0 = pops;
    bus.rsp_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_count", 64'(pops - pops0), 64'd4);
    @(negedge clk);
    check("drain_idle", 64'(bus.idle_o), 64'd1);
    @(posedge clk);
    #1;
    read_burst(10'h030, 2, acc);
    check("resume_accepts", 64'(acc), 64'd2);
    repeat (3) @(posedge clk);
    #1;

    // Read then write to the same address next cycle: the read sees the old word.
    read_burst(10'h005, 1, acc);
    do_write(10'h005, 64'hFEED_FACE_CAFE_BABE, 8'hFF);
    read_burst(10'h005, 1, acc);
    repeat (3) @(posedge clk);
    #1;

    // Reset with two buffered responses and one read in flight.
    bus.rsp_ready_i = 1'b0;
    read_burst(10'h040, 3, acc);
    check("pre_rst_accepts", 64'(acc), 64'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("mid_rst_idle", 64'(bus.idle_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(bus.rsp_valid_o), 64'd0);
      check("post_rst_idle", 64'(bus.idle_o), 64'd1);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
